// File: rtl/pc_pkg.sv
// Shared opcode definitions for the pc_ras fetch block.
package pc_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    NEXT     = 3'd0,
    JUMP_ABS = 3'd1,
    JUMP_REL = 3'd2,
    CALL     = 3'd3,
    RET      = 3'd4
  } pc_op_t;

endpackage

// File: rtl/pc_ras_stack.sv
// Return-address stack with occupancy tracking. Define PC_RAS_WRAP_EN to make
// it circular (a push when full overwrites the oldest entry instead of being dropped).
module pc_ras_stack #(
  parameter int PC_W      = 8,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] din,
  output logic [PC_W-1:0] top,
  output logic            full,
  output logic            empty,
  output logic            overflow,
  output logic            underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);

  logic [PC_W-1:0]  mem [RAS_DEPTH];
  logic [PTR_W-1:0] sp;     // next free slot
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == (PTR_W+1)'(RAS_DEPTH));
  assign empty = (count == '0);
  assign top   = mem[sp - PTR_W'(1)];

`ifdef PC_RAS_WRAP_EN
  // The slot at sp holds the oldest entry once full, so a plain push overwrites it.
  assign do_push  = push;
  assign overflow = 1'b0;
`else
  assign do_push  = push & ~full;
  assign overflow = push & full;
`endif

  assign do_pop    = pop & ~push & ~empty;
  assign underflow = pop & ~push & empty;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp    <= '0;
      count <= '0;
    end else if (do_push) begin
      sp <= sp + PTR_W'(1);
      if (!full) count <= count + (PTR_W+1)'(1);
    end else if (do_pop) begin
      sp    <= sp - PTR_W'(1);
      count <= count - (PTR_W+1)'(1);
    end
  end

  // NOTE: the storage array is deliberately not reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[sp] <= din;
  end

endmodule

// File: rtl/pc_ras.sv
// Program counter with relative branches and an internal return-address stack.
// Optional macro PC_RAS_WRAP_EN selects a circular stack (see pc_ras_stack).
module pc_ras
  import pc_pkg::*;
#(
  parameter int PC_W      = 8,
  parameter int INC       = 1,
  parameter int RAS_DEPTH = 4,
  parameter int RESET_VEC = 0
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            stall,
  input  logic [2:0]      pc_op,
  input  logic [PC_W-1:0] immediate,
  output logic [PC_W-1:0] PC,
  output logic            ras_full,
  output logic            ras_empty,
  output logic            ras_err
);

  localparam logic [PC_W-1:0] INC_V = PC_W'(INC);

  pc_op_t          op;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] ret_addr;
  logic            push;
  logic            pop;
  logic            overflow;
  logic            underflow;

  assign op = pc_op_t'(pc_op);

  pc_ras_stack #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_stack (
    .clk       (CLK),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .din       (PC + INC_V),
    .top       (ret_addr),
    .full      (ras_full),
    .empty     (ras_empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
  always_comb begin
    pc_next = PC + INC_V;
    push    = 1'b0;
    pop     = 1'b0;
    case (op)
      JUMP_ABS: pc_next = immediate;
      // Offset and PC share a width, so modulo-2^PC_W addition is the sign-extended sum.
      JUMP_REL: pc_next = PC + immediate;
      CALL: begin
        pc_next = immediate;
        push    = ~stall;
      end
      RET: begin
        pop = ~stall;
        if (!ras_empty) pc_next = ret_addr;
      end
      default: pc_next = PC + INC_V;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      PC      <= PC_W'(RESET_VEC);
      ras_err <= 1'b0;
    end else if (!stall) begin
      PC      <= pc_next;
      ras_err <= ras_err | overflow | underflow;
    end
  end

endmodule

// File: tb/tb_pc_ras.sv
// Directed self-checking bench for pc_ras at PC_W=8, INC=1, RAS_DEPTH=4, RESET_VEC=0.
module tb_pc_ras;
  import pc_pkg::*;

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic       stall = 1'b0;
  logic [2:0] pc_op = 3'd0;
  logic [7:0] immediate = 8'd0;
  logic [7:0] PC;
  logic       ras_full, ras_empty, ras_err;

  int passed = 0;
  int total  = 0;

  pc_ras #(.PC_W(8), .INC(1), .RAS_DEPTH(4), .RESET_VEC(0)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .stall     (stall),
    .pc_op     (pc_op),
    .immediate (immediate),
    .PC        (PC),
    .ras_full  (ras_full),
    .ras_empty (ras_empty),
    .ras_err   (ras_err)
  );

  always #5 CLK = ~CLK;

  // Present one op, clock it, and return #1 after the edge for sampling.
  task automatic do_op(input pc_op_t op, input logic [7:0] imm);
    pc_op = op;
    immediate = imm;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input logic with_stall);
    reset = 1'b1;
    stall = with_stall;
    pc_op = CALL;
    immediate = 8'hAA;
    @(posedge CLK);
    #1;
    reset = 1'b0;
    stall = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    total++;
    if (PC !== 8'd0 || ras_empty !== 1'b1 || ras_full !== 1'b0 || ras_err !== 1'b0)
      $display("FAIL reset_state: PC=%0d empty=%b full=%b err=%b, want PC=0 empty=1 full=0 err=0",
               PC, ras_empty, ras_full, ras_err);
    else passed++;
  endtask

  task automatic test_next();
    for (int i = 1; i <= 10; i++) begin
      do_op(NEXT, 8'd0);
      total++;
      if (PC !== 8'(i) || ras_empty !== 1'b1 || ras_err !== 1'b0)
        $display("FAIL next_%0d: PC=%0d empty=%b err=%b, want PC=%0d empty=1 err=0",
                 i, PC, ras_empty, ras_err, i);
      else passed++;
    end
  endtask

  task automatic test_jump_abs();
    logic [7:0] exp_a [4] = '{8'd50, 8'd51, 8'd52, 8'd53};
    logic [7:0] exp_b [4] = '{8'd254, 8'd255, 8'd0, 8'd1};
    for (int i = 0; i < 4; i++) begin
      do_op(i == 0 ? JUMP_ABS : NEXT, 8'd50);
      total++;
      if (PC !== exp_a[i]) $display("FAIL jump_abs_a%0d: PC=%0d want %0d", i, PC, exp_a[i]);
      else passed++;
    end
    for (int i = 0; i < 4; i++) begin
      do_op(i == 0 ? JUMP_ABS : NEXT, 8'd254);
      total++;
      if (PC !== exp_b[i]) $display("FAIL jump_abs_wrap%0d: PC=%0d want %0d", i, PC, exp_b[i]);
      else passed++;
    end
  endtask

  task automatic test_jump_rel();
    do_op(JUMP_ABS, 8'd20);
    do_op(JUMP_REL, 8'hFB);
    total++;
    if (PC !== 8'd15) $display("FAIL jump_rel_neg: PC=%0d want 15", PC);
    else passed++;
    do_op(JUMP_REL, 8'd10);
    total++;
    if (PC !== 8'd25) $display("FAIL jump_rel_pos: PC=%0d want 25", PC);
    else passed++;
  endtask

  task automatic test_call_ret();
    logic [7:0] tgt [4] = '{8'd40, 8'd60, 8'd80, 8'd90};
    logic [7:0] rets [4] = '{8'd81, 8'd61, 8'd41, 8'd11};
    do_op(JUMP_ABS, 8'd10);
    do_op(CALL, 8'd100);
    total++;
    if (PC !== 8'd100 || ras_empty !== 1'b0) $display("FAIL call_single: PC=%0d empty=%b want 100 0", PC, ras_empty);
    else passed++;
    do_op(NEXT, 8'd0);
    do_op(RET, 8'd0);
    total++;
    if (PC !== 8'd11 || ras_empty !== 1'b1) $display("FAIL ret_single: PC=%0d empty=%b want 11 1", PC, ras_empty);
    else passed++;
    do_op(JUMP_ABS, 8'd10);
    for (int i = 0; i < 4; i++) begin
      do_op(CALL, tgt[i]);
      total++;
      if (PC !== tgt[i] || ras_full !== (i == 3))
        $display("FAIL call_chain%0d: PC=%0d full=%b want PC=%0d full=%b", i, PC, ras_full, tgt[i], i == 3);
      else passed++;
    end
    for (int i = 0; i < 4; i++) begin
      do_op(RET, 8'd0);
      total++;
      if (PC !== rets[i] || ras_empty !== (i == 3) || ras_full !== 1'b0)
        $display("FAIL ret_chain%0d: PC=%0d empty=%b full=%b want PC=%0d empty=%b full=0",
                 i, PC, ras_empty, ras_full, rets[i], i == 3);
      else passed++;
    end
    total++;
    if (ras_err !== 1'b0) $display("FAIL call_ret_err: err=%b want 0", ras_err);
    else passed++;
  endtask

  task automatic test_overflow();
    logic [7:0] tgt [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
`ifdef PC_RAS_WRAP_EN
    logic [7:0] rets [4] = '{8'd41, 8'd31, 8'd21, 8'd11};
    logic       exp_err = 1'b0;
    logic [7:0] exp_under = 8'd12;
`else
    logic [7:0] rets [4] = '{8'd31, 8'd21, 8'd11, 8'd1};
    logic       exp_err = 1'b1;
    logic [7:0] exp_under = 8'd2;
`endif
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) do_op(CALL, tgt[i]);
    do_op(CALL, 8'd200);
    total++;
    if (PC !== 8'd200 || ras_full !== 1'b1 || ras_err !== exp_err)
      $display("FAIL overflow_call: PC=%0d full=%b err=%b want 200 1 %b", PC, ras_full, ras_err, exp_err);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      do_op(RET, 8'd0);
      total++;
      if (PC !== rets[i]) $display("FAIL overflow_ret%0d: PC=%0d want %0d", i, PC, rets[i]);
      else passed++;
    end
    do_op(RET, 8'd0);
    total++;
    if (PC !== exp_under || ras_empty !== 1'b1 || ras_err !== 1'b1)
      $display("FAIL underflow_ret: PC=%0d empty=%b err=%b want %0d 1 1", PC, ras_empty, ras_err, exp_under);
    else passed++;
    do_op(NEXT, 8'd0);
    total++;
    if (ras_err !== 1'b1) $display("FAIL err_sticky: err=%b want 1", ras_err);
    else passed++;
  endtask

  task automatic test_stall_reset();
    do_reset(1'b0);
    do_op(RET, 8'd0);      // underflow: PC=1, err=1
    do_op(CALL, 8'd30);    // pushes 2
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_op(CALL, 8'd99);
      total++;
      if (PC !== 8'd30 || ras_empty !== 1'b0 || ras_full !== 1'b0 || ras_err !== 1'b1)
        $display("FAIL stall_hold%0d: PC=%0d empty=%b full=%b err=%b want 30 0 0 1",
                 i, PC, ras_empty, ras_full, ras_err);
      else passed++;
    end
    stall = 1'b0;
    do_op(RET, 8'd0);
    total++;
    if (PC !== 8'd2 || ras_empty !== 1'b1) $display("FAIL stall_ret: PC=%0d empty=%b want 2 1", PC, ras_empty);
    else passed++;
    do_op(CALL, 8'd50);
    do_op(CALL, 8'd70);
    do_reset(1'b0);
    total++;
    if (PC !== 8'd0 || ras_empty !== 1'b1 || ras_err !== 1'b0)
      $display("FAIL reset_chain: PC=%0d empty=%b err=%b want 0 1 0", PC, ras_empty, ras_err);
    else passed++;
    do_op(RET, 8'd0);
    total++;
    if (PC !== 8'd1 || ras_err !== 1'b1) $display("FAIL reset_discard: PC=%0d err=%b want 1 1", PC, ras_err);
    else passed++;
    do_op(CALL, 8'd60);
    do_reset(1'b1);
    total++;
    if (PC !== 8'd0 || ras_empty !== 1'b1 || ras_err !== 1'b0)
      $display("FAIL reset_stall: PC=%0d empty=%b err=%b want 0 1 0", PC, ras_empty, ras_err);
    else passed++;
    do_op(pc_op_t'(3'd6), 8'd77);
    total++;
    if (PC !== 8'd1) $display("FAIL op_reserved: PC=%0d want 1", PC);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_next();
    test_jump_abs();
    test_jump_rel();
    test_call_ret();
    test_overflow();
    test_stall_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
